// File: rtl/manchester_pkg.sv
// Shared constants for the Manchester TX path: escape symbols,
// frame delimiters and the framer state encoding.
package manchester_pkg;

    localparam logic [7:0] START_WORD      = 8'hD5;
    localparam logic [7:0] ESCAPE_SYMBOL   = 8'hE5;
    localparam logic [7:0] REPLACE_SYMBOL  = 8'hF5;
    localparam logic [7:0] PREAMBLE_SYMBOL = 8'h55;
    localparam logic [7:0] IDLE_SYMBOL     = 8'h00;

    typedef logic [2:0] framer_state_t;

    localparam framer_state_t IDLE     = 3'd0;
    localparam framer_state_t PREAMBLE = 3'd1;
    localparam framer_state_t SOF      = 3'd2;
    localparam framer_state_t PAYLOAD  = 3'd3;
    localparam framer_state_t IFG      = 3'd4;

endpackage

// File: rtl/manchester_framer.sv
// Wraps escaped AXI-Stream packets in preamble + start word frames.
// Define MANCHESTER_FRAMER_IFG_EN to append IFG_LEN idle bytes per frame.
module manchester_framer
    import manchester_pkg::*;
#(
    parameter int unsigned                 DATA_WIDTH      = 8,
    parameter int unsigned                 PREAMBLE_LEN    = 4,
    parameter logic [DATA_WIDTH-1:0]       PREAMBLE_SYMBOL = manchester_pkg::PREAMBLE_SYMBOL,
    parameter logic [DATA_WIDTH-1:0]       START_WORD      = manchester_pkg::START_WORD,
    parameter int unsigned                 IFG_LEN         = 2,
    parameter logic [DATA_WIDTH-1:0]       IDLE_SYMBOL     = manchester_pkg::IDLE_SYMBOL
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

`ifdef MANCHESTER_FRAMER_IFG_EN
    localparam logic [7:0] IFG_LAST = 8'(IFG_LEN - 1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(IFG_LEN), IDLE_SYMBOL};
`endif

    framer_state_t         state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  load;

    // One load slot per cycle in which the output register is free
    assign load = !tvalid_q || m_axis_tready;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = (PREAMBLE_LEN == 0) ? SOF : PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (load) begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        state_d = SOF;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SOF: begin
                if (load) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (load && s_axis_tvalid && s_axis_tlast) begin
`ifdef MANCHESTER_FRAMER_IFG_EN
                    state_d = IFG;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef MANCHESTER_FRAMER_IFG_EN
            IFG: begin
                if (load) begin
                    if (cnt_q == IFG_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        s_axis_tready = 1'b0;
        busy          = (state_q != IDLE);
        if (load) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            unique case (state_q)
                PREAMBLE: begin
                    tdata_d  = PREAMBLE_SYMBOL;
                    tvalid_d = 1'b1;
                end
                SOF: begin
                    tdata_d  = START_WORD;
                    tvalid_d = 1'b1;
                end
                PAYLOAD: begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        tdata_d  = s_axis_tdata;
                        tlast_d  = s_axis_tlast;
                        tvalid_d = 1'b1;
                    end
                end
`ifdef MANCHESTER_FRAMER_IFG_EN
                IFG: begin
                    tdata_d  = IDLE_SYMBOL;
                    tvalid_d = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
